sram_like_arbiter: RTL and testbench

// - Merges the CPU core's instruction and data SRAM-like master channels onto one downstream SRAM-like master port.
// - Sits between the pipeline top and the shared bus bridge or cache.
// - Arbitrates address phases and holds the granted request stable until it is accepted.
// - Routes each in-order data_ok back to the requester that issued it, using an ID FIFO.

---
 rtl/sram_like_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_like_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Merges inst and data SRAM-like masters onto one downstream port; data_ok is routed back through an ID FIFO.
// Zero-latency request mux and response routing; a stalled grant is locked until m_addr_ok; issue stalls at MAX_OUT.
// Define ARB_RR_EN for a round-robin tie-break in IDLE (default: fixed data priority).
module sram_like_arbiter #(
   parameter int MAX_OUT = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [PTR_W-1:0]   wptr;
   logic [PTR_W-1:0]   rptr;
   logic [MAX_OUT-1:0] id_q;

   logic gnt_vld;
   logic gnt_id;
   logic tie_id;
   logic granted_req;
   logic sel;
   logic issue;
   logic accept;
   logic pop;
   logic head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

`ifdef ARB_RR_EN
   logic last_id;

   // Tie goes to whichever channel did not win the most recent acceptance.
   always_ff @(posedge clk) begin
      if (!resetn)
         last_id <= 1'b0;
      else if (accept)
         last_id <= gnt_id;
   end

   assign tie_id = ~last_id;
`else
   assign tie_id = 1'b1;
`endif

   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      case (state)
         LOCK_I: begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b0;
         end
         LOCK_D: begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
         default: begin
            if (inst_req && data_req) begin
               gnt_vld = 1'b1;
               gnt_id  = tie_id;
            end else if (data_req) begin
               gnt_vld = 1'b1;
               gnt_id  = 1'b1;
            end else if (inst_req) begin
               gnt_vld = 1'b1;
               gnt_id  = 1'b0;
            end
         end
      endcase
   end

   assign granted_req = gnt_vld & (gnt_id ? data_req : inst_req);
   assign sel         = resetn & granted_req;
   // Gate on the registered count only, so a slot freed this cycle is reusable next cycle.
   assign issue       = sel & (cnt < CNT_MAX);
   assign accept      = issue & m_addr_ok;
   assign pop         = resetn & m_data_ok & (cnt != '0);
   assign head        = id_q[rptr];

   assign m_req   = issue;
   assign m_wr    = sel & (gnt_id ? data_wr : inst_wr);
   assign m_size  = sel ? (gnt_id ? data_size  : inst_size)  : '0;
   assign m_addr  = sel ? (gnt_id ? data_addr  : inst_addr)  : '0;
   assign m_wdata = sel ? (gnt_id ? data_wdata : inst_wdata) : '0;

   assign inst_addr_ok = accept & ~gnt_id;
   assign data_addr_ok = accept &  gnt_id;
   assign inst_data_ok = pop & ~head;
   assign data_data_ok = pop &  head;
   assign inst_rdata   = resetn ? m_rdata : '0;
   assign data_rdata   = resetn ? m_rdata : '0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         id_q  <= '0;
      end else begin
         case (state)
            IDLE:    if (issue && !m_addr_ok) state <= gnt_id ? LOCK_D : LOCK_I;
            LOCK_I,
            LOCK_D:  if (m_addr_ok) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (accept) begin
            id_q[wptr] <= gnt_id;
            wptr       <= ptr_inc(wptr);
         end
         if (pop)
            rptr <= ptr_inc(rptr);

         case ({accept, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_sram_like_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, m_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        m_req, m_wr, m_addr_ok, m_data_ok;
   logic [31:0] m_addr, m_wdata, m_rdata;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(.MAX_OUT(2), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
      m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
   endtask

   task automatic test_reset();
      resetn = 0; clr();
      step();
      inst_req = 1; inst_addr = 32'h1234; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      vectors++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
      vectors++; if (m_addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0", m_addr); end
      vectors++; if (inst_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b want 0", inst_addr_ok); end
      vectors++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b want 0", inst_data_ok); end
      vectors++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", inst_rdata); end
      step();
      clr(); resetn = 1;
      step();
   endtask

   task automatic test_single_inst();
      inst_req = 1; inst_addr = 32'hBFC0_0000; m_addr_ok = 1;
      @(negedge clk);
      vectors++; if (m_req !== 1'b1) begin errors++; $display("FAIL single_m_req: got %b want 1", m_req); end
      vectors++; if (m_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_m_addr: got %h want bfc00000", m_addr); end
      vectors++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL single_inst_addr_ok: got %b want 1", inst_addr_ok); end
      vectors++; if (data_addr_ok !== 1'b0) begin errors++; $display("FAIL single_data_addr_ok: got %b want 0", data_addr_ok); end
      step();
      clr();
      @(negedge clk);
      vectors++; if (m_req !== 1'b0) begin errors++; $display("FAIL single_idle_m_req: got %b want 0", m_req); end
      vectors++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL single_early_data_ok: got %b want 0", inst_data_ok); end
      step();
      m_data_ok = 1; m_rdata = 32'h2408_0001;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL single_inst_data_ok: got %b want 1", inst_data_ok); end
      vectors++; if (inst_rdata !== 32'h2408_0001) begin errors++; $display("FAIL single_rdata: got %h want 24080001", inst_rdata); end
      vectors++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL single_data_data_ok: got %b want 0", data_data_ok); end
      step();
      clr();
      step();
   endtask

   task automatic test_tie();
      logic [31:0] first_exp, second_exp;
      inst_req = 1; inst_addr = 32'h8000_1000; data_req = 1; data_addr = 32'h8000_2000; m_addr_ok = 1;
      @(negedge clk);
      vectors++; if (m_addr !== 32'h8000_2000) begin errors++; $display("FAIL tie_first: got %h want 80002000", m_addr); end
      vectors++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL tie_first_ok: got d=%b i=%b want d=1 i=0", data_addr_ok, inst_addr_ok); end
      step();
      data_req = 0;
      @(negedge clk);
      vectors++; if (m_addr !== 32'h8000_1000) begin errors++; $display("FAIL tie_second: got %h want 80001000", m_addr); end
      vectors++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL tie_second_ok: got %b want 1", inst_addr_ok); end
      step();
      clr(); m_data_ok = 1;
      @(negedge clk);
      vectors++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL tie_resp1: got %b want 1", data_data_ok); end
      step();
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL tie_resp2: got %b want 1", inst_data_ok); end
      step();
      // make data the most recent winner, then tie again
      clr(); data_req = 1; data_addr = 32'h8000_2000; m_addr_ok = 1;
      step();
      clr(); m_data_ok = 1;
      step();
`ifdef ARB_RR_EN
      first_exp = 32'h8000_1000; second_exp = 32'h8000_2000;
`else
      first_exp = 32'h8000_2000; second_exp = 32'h8000_1000;
`endif
      clr(); inst_req = 1; inst_addr = 32'h8000_1000; data_req = 1; data_addr = 32'h8000_2000; m_addr_ok = 1;
      @(negedge clk);
      vectors++; if (m_addr !== first_exp) begin errors++; $display("FAIL tie2_first: got %h want %h", m_addr, first_exp); end
      step();
      if (first_exp == 32'h8000_2000) data_req = 0; else inst_req = 0;
      @(negedge clk);
      vectors++; if (m_addr !== second_exp) begin errors++; $display("FAIL tie2_second: got %h want %h", m_addr, second_exp); end
      step();
      clr(); m_data_ok = 1;
      step(); step();
      clr();
      step();
   endtask

   task automatic test_lock();
      inst_req = 1; inst_addr = 32'h0000_0A00; data_addr = 32'h0000_0B00; m_addr_ok = 0;
      @(negedge clk);
      vectors++; if (m_addr !== 32'h0A00 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c0: got addr=%h ok=%b want 00000a00/0", m_addr, inst_addr_ok); end
      step();
      data_req = 1;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         vectors++; if (m_addr !== 32'h0A00 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c%0d: got addr=%h d_ok=%b want 00000a00/0", c, m_addr, data_addr_ok); end
         step();
      end
      m_addr_ok = 1;
      @(negedge clk);
      vectors++; if (m_addr !== 32'h0A00 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL lock_c3: got addr=%h i=%b d=%b want 00000a00/1/0", m_addr, inst_addr_ok, data_addr_ok); end
      step();
      inst_req = 0;
      @(negedge clk);
      vectors++; if (m_addr !== 32'h0B00 || data_addr_ok !== 1'b1) begin errors++; $display("FAIL lock_data_after: got addr=%h ok=%b want 00000b00/1", m_addr, data_addr_ok); end
      step();
      clr(); m_data_ok = 1;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp_inst: got %b want 1", inst_data_ok); end
      step();
      @(negedge clk);
      vectors++; if (data_data_ok !== 1'b1) begin errors++; $display("FAIL lock_resp_data: got %b want 1", data_data_ok); end
      step();
      clr();
      step();
   endtask

   task automatic test_full();
      inst_req = 1; inst_addr = 32'h100; m_addr_ok = 1;
      step(); step();
      @(negedge clk);
      vectors++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("FAIL full_stall: got req=%b ok=%b want 0/0", m_req, inst_addr_ok); end
      step();
      m_data_ok = 1;
      @(negedge clk);
      vectors++; if (m_req !== 1'b0) begin errors++; $display("FAIL full_same_cycle: got %b want 0", m_req); end
      vectors++; if (inst_data_ok !== 1'b1) begin errors++; $display("FAIL full_pop: got %b want 1", inst_data_ok); end
      step();
      m_data_ok = 0;
      @(negedge clk);
      vectors++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_resume: got req=%b ok=%b want 1/1", m_req, inst_addr_ok); end
      step();
      clr(); m_data_ok = 1;
      step(); step();
      clr();
      step();
   endtask

   task automatic test_ordering();
      data_req = 1; data_addr = 32'h200; m_addr_ok = 1;
      step();
      clr(); inst_req = 1; inst_addr = 32'h300; m_addr_ok = 1;
      step();
      clr(); m_data_ok = 1; m_rdata = 32'h11;
      @(negedge clk);
      vectors++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'h11) begin errors++; $display("FAIL order_first: got d=%b i=%b rd=%h want 1/0/11", data_data_ok, inst_data_ok, data_rdata); end
      step();
      m_rdata = 32'h22;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h22) begin errors++; $display("FAIL order_second: got i=%b d=%b rd=%h want 1/0/22", inst_data_ok, data_data_ok, inst_rdata); end
      step();
      m_rdata = 32'h99;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL order_spurious: got i=%b d=%b want 0/0", inst_data_ok, data_data_ok); end
      step();
      clr();
      step();
   endtask

   task automatic test_back_to_back();
      data_req = 1; data_addr = 32'h400; m_addr_ok = 1;
      step();
      clr(); inst_req = 1; inst_addr = 32'h500; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h33;
      @(negedge clk);
      vectors++; if (inst_addr_ok !== 1'b1 || data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_overlap: got i_aok=%b d_dok=%b i_dok=%b want 1/1/0", inst_addr_ok, data_data_ok, inst_data_ok); end
      step();
      clr(); m_data_ok = 1; m_rdata = 32'h44;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_second: got i=%b d=%b want 1/0", inst_data_ok, data_data_ok); end
      step();
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL b2b_empty: got i=%b d=%b want 0/0", inst_data_ok, data_data_ok); end
      step();
      clr();
      step();
   endtask

   task automatic test_reset_mid();
      data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
      step();
      m_addr_ok = 0;
      @(negedge clk);
      vectors++; if (m_req !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b want 1", m_req); end
      step();
      resetn = 0;
      @(negedge clk);
      vectors++; if (m_req !== 1'b0 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL rmid_in_reset: got req=%b ok=%b want 0/0", m_req, data_addr_ok); end
      step();
      resetn = 1; clr(); m_data_ok = 1; m_rdata = 32'h77;
      @(negedge clk);
      vectors++; if (m_req !== 1'b0) begin errors++; $display("FAIL rmid_m_req: got %b want 0", m_req); end
      vectors++; if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_stale_resp: got d=%b i=%b want 0/0", data_data_ok, inst_data_ok); end
      step();
      clr(); inst_req = 1; inst_addr = 32'h700; m_addr_ok = 1;
      @(negedge clk);
      vectors++; if (m_req !== 1'b1 || m_addr !== 32'h700 || inst_addr_ok !== 1'b1) begin errors++; $display("FAIL rmid_idle: got req=%b addr=%h ok=%b want 1/00000700/1", m_req, m_addr, inst_addr_ok); end
      step();
      clr(); m_data_ok = 1; m_rdata = 32'h55;
      @(negedge clk);
      vectors++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin errors++; $display("FAIL rmid_resp: got i=%b d=%b want 1/0", inst_data_ok, data_data_ok); end
      step();
      clr();
      step();
   endtask

   initial begin
      test_reset();
      test_single_inst();
      test_tie();
      test_lock();
      test_full();
      test_ordering();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
